// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset vector, state encoding.
package fetch_pkg;

  localparam int unsigned XLEN = 16;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 16'h0000;

  typedef enum logic [0:0] {
    StFetch   = 1'b0,
    StWaitDec = 1'b1
  } fetch_state_e;

  // Instructions are halfword aligned; the low address bit is always forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(1);
  endfunction

endpackage

// File: rtl/pcalu.sv
// Sequential PC adder: next instruction address, 16-bit modulo (wraps silently).
module pcalu
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] PCIN,
  output logic [XLEN-1:0] PCOUT
);

  assign PCOUT = PCIN + XLEN'(2);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one request to instruction memory at a time, single-entry
// instruction register handed to decode with a valid/ready handshake, redirect on branches.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [XLEN-1:0] IMEM_DATA,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IR_VALID,
  input  logic            IR_READY,
  output logic [XLEN-1:0] IR_OUT,
  output logic [XLEN-1:0] IR_PC
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  // Request is registered so it stays low through reset without a path from RST_N.
  logic            req_q, req_d;
  logic [XLEN-1:0] pc_seq;

  pcalu u_pcalu (
    .PCIN  (pc_q),
    .PCOUT (pc_seq)
  );

  // Next-state logic: redirect beats everything; otherwise fetch/handshake progression.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (REDIRECT) begin
      // Any data acknowledged this cycle belongs to the wrong path and is dropped.
      pc_d       = align_pc(REDIRECT_PC);
      ir_valid_d = 1'b0;
      state_d    = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (req_q && IMEM_ACK) begin
            ir_d       = IMEM_DATA;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_seq;
            state_d    = StWaitDec;
          end
        end
        StWaitDec: begin
          if (ir_valid_q && IR_READY) begin
            ir_valid_d = 1'b0;
            state_d    = StFetch;
          end
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end

    req_d = (state_d == StFetch);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StFetch;
      pc_q       <= RESET_VECTOR;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign IR_VALID  = ir_valid_q;
  assign IR_OUT    = ir_q;
  assign IR_PC     = ir_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences feed a scoreboard of expected decode handoffs,
// a monitor checks every accepted instruction; a random phase checks PC sequencing.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } exp_t;

  logic        CLK;
  logic        RST_N;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [15:0] IMEM_DATA;
  logic        REDIRECT;
  logic [15:0] REDIRECT_PC;
  logic        IR_VALID;
  logic        IR_READY;
  logic [15:0] IR_OUT;
  logic [15:0] IR_PC;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  bit   stress_mode = 1'b0;
  logic [15:0] last_acc = 16'h0000;
  logic [15:0] last_tgt = 16'h0000;
  bit   have_acc = 1'b0;

  fetch_unit #(
    .RESET_VECTOR (16'h0000)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_ACK    (IMEM_ACK),
    .IMEM_DATA   (IMEM_DATA),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .IR_VALID    (IR_VALID),
    .IR_READY    (IR_READY),
    .IR_OUT      (IR_OUT),
    .IR_PC       (IR_PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; registered outputs are settled by then.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] ir, input logic [15:0] pc);
    exp_t e;
    e.ir = ir;
    e.pc = pc;
    sb.push_back(e);
  endtask

  // Monitor: an instruction is taken by decode at the coming edge when valid and ready
  // are both up, with no redirect and no reset.
  always @(negedge CLK) begin
    exp_t e;
    bit   ok;
    if (RST_N && !REDIRECT && IR_VALID && IR_READY) begin
      if (!stress_mode) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: unexpected accept IR_PC=%h IR_OUT=%h, expected none",
                   IR_PC, IR_OUT);
        end else begin
          e = sb.pop_front();
          check("sb_ir_out", IR_OUT, e.ir);
          check("sb_ir_pc", IR_PC, e.pc);
        end
      end else begin
        check("stress_data", IR_OUT, IR_PC ^ 16'hA5A5);
        ok = (IR_PC == last_tgt) || (have_acc && (IR_PC == last_acc + 16'd2));
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL stress_pc_seq: got %h expected %h or %h", IR_PC,
                   last_acc + 16'd2, last_tgt);
        end
        last_acc = IR_PC;
        have_acc = 1'b1;
      end
    end
    if (stress_mode && RST_N && REDIRECT) last_tgt = REDIRECT_PC & 16'hFFFE;
  end

  initial begin
    RST_N       = 1'b0;
    IMEM_ACK    = 1'b0;
    IMEM_DATA   = 16'h0000;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 16'h0000;
    IR_READY    = 1'b0;

    // Reset: request held low, IR cleared.
    tick();
    tick();
    check("rst_req", {15'd0, IMEM_REQ}, 16'd0);
    check("rst_valid", {15'd0, IR_VALID}, 16'd0);
    check("rst_ir_out", IR_OUT, 16'h0000);
    check("rst_ir_pc", IR_PC, 16'h0000);

    RST_N = 1'b1;
    tick();
    check("rel_req", {15'd0, IMEM_REQ}, 16'd1);
    check("rel_addr", IMEM_ADDR, 16'h0000);

    // One wait cycle, then ACK with decode ready.
    tick();
    check("wait_req", {15'd0, IMEM_REQ}, 16'd1);
    check("wait_addr", IMEM_ADDR, 16'h0000);
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'h1234;
    IR_READY  = 1'b1;
    push(16'h1234, 16'h0000);
    tick();
    IMEM_ACK = 1'b0;
    check("f1_valid", {15'd0, IR_VALID}, 16'd1);
    check("f1_ir_out", IR_OUT, 16'h1234);
    check("f1_ir_pc", IR_PC, 16'h0000);
    check("f1_req", {15'd0, IMEM_REQ}, 16'd0);
    check("f1_addr", IMEM_ADDR, 16'h0002);
    tick();
    check("f1_next_valid", {15'd0, IR_VALID}, 16'd0);
    check("f1_next_req", {15'd0, IMEM_REQ}, 16'd1);
    check("f1_next_addr", IMEM_ADDR, 16'h0002);

    // Decode stalls five cycles: IR held, no request.
    IR_READY  = 1'b0;
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'hABCD;
    push(16'hABCD, 16'h0002);
    tick();
    IMEM_ACK = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {15'd0, IR_VALID}, 16'd1);
      check("stall_ir_out", IR_OUT, 16'hABCD);
      check("stall_req", {15'd0, IMEM_REQ}, 16'd0);
      tick();
    end
    IR_READY = 1'b1;
    tick();
    check("acc_valid", {15'd0, IR_VALID}, 16'd0);
    check("acc_req", {15'd0, IMEM_REQ}, 16'd1);
    check("acc_addr", IMEM_ADDR, 16'h0004);
    // Ready with nothing valid changes nothing.
    tick();
    check("idle_ready_req", {15'd0, IMEM_REQ}, 16'd1);
    check("idle_ready_addr", IMEM_ADDR, 16'h0004);
    check("idle_ready_valid", {15'd0, IR_VALID}, 16'd0);

    // Redirect in the same cycle as ACK: data dropped, target aligned.
    REDIRECT    = 1'b1;
    REDIRECT_PC = 16'h0041;
    IMEM_ACK    = 1'b1;
    IMEM_DATA   = 16'hDEAD;
    tick();
    REDIRECT = 1'b0;
    IMEM_ACK = 1'b0;
    check("rd_valid", {15'd0, IR_VALID}, 16'd0);
    check("rd_req", {15'd0, IMEM_REQ}, 16'd1);
    check("rd_addr", IMEM_ADDR, 16'h0040);

    // Redirect while waiting on decode beats IR_READY and drops the IR.
    IR_READY  = 1'b0;
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'h5555;
    tick();
    IMEM_ACK = 1'b0;
    check("rw_valid", {15'd0, IR_VALID}, 16'd1);
    check("rw_ir_pc", IR_PC, 16'h0040);
    REDIRECT    = 1'b1;
    REDIRECT_PC = 16'hFFFE;
    IR_READY    = 1'b1;
    tick();
    REDIRECT = 1'b0;
    check("rw2_valid", {15'd0, IR_VALID}, 16'd0);
    check("rw2_addr", IMEM_ADDR, 16'hFFFE);
    check("rw2_req", {15'd0, IMEM_REQ}, 16'd1);

    // Wrap at the top of the address space.
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'h7777;
    push(16'h7777, 16'hFFFE);
    tick();
    IMEM_ACK = 1'b0;
    check("wrap_ir_pc", IR_PC, 16'hFFFE);
    check("wrap_addr", IMEM_ADDR, 16'h0000);
    tick();
    check("wrap_req", {15'd0, IMEM_REQ}, 16'd1);

    // ACK while no request is outstanding is ignored.
    IR_READY  = 1'b0;
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'h1111;
    push(16'h1111, 16'h0000);
    tick();
    IMEM_DATA = 16'h2222;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("noreq_ack_ir", IR_OUT, 16'h1111);
      check("noreq_ack_addr", IMEM_ADDR, 16'h0002);
    end
    IMEM_ACK = 1'b0;
    IR_READY = 1'b1;
    tick();
    check("noreq_done_req", {15'd0, IMEM_REQ}, 16'd1);

    // Reset during WAIT_DEC abandons the instruction.
    IR_READY  = 1'b0;
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'h3333;
    tick();
    IMEM_ACK = 1'b0;
    check("rwd_valid", {15'd0, IR_VALID}, 16'd1);
    RST_N    = 1'b0;
    IR_READY = 1'b1;
    tick();
    check("rwd_rst_valid", {15'd0, IR_VALID}, 16'd0);
    check("rwd_rst_ir", IR_OUT, 16'h0000);
    check("rwd_rst_req", {15'd0, IMEM_REQ}, 16'd0);
    RST_N    = 1'b1;
    IR_READY = 1'b0;
    tick();
    check("rwd_rel_req", {15'd0, IMEM_REQ}, 16'd1);
    check("rwd_rel_addr", IMEM_ADDR, 16'h0000);
    check("sb_drained", 16'(sb.size()), 16'd0);

    // Random stress; memory returns data derived from the address.
    stress_mode = 1'b1;
    REDIRECT    = 1'b1;
    REDIRECT_PC = 16'hFFF1;
    tick();
    for (int i = 0; i < 10000; i++) begin
      check("stress_excl", {15'd0, IMEM_REQ & IR_VALID}, 16'd0);
      IMEM_ACK    = ($urandom_range(0, 1) == 1);
      IMEM_DATA   = IMEM_ADDR ^ 16'hA5A5;
      IR_READY    = ($urandom_range(0, 3) != 0);
      REDIRECT    = ($urandom_range(0, 19) == 0);
      REDIRECT_PC = 16'($urandom);
      tick();
    end
    REDIRECT = 1'b0;
    IMEM_ACK = 1'b0;
    IR_READY = 1'b0;
    tick();
    n_checks++;
    if (!have_acc) begin
      n_fail++;
      $display("FAIL stress_progress: got 0 accepts expected at least 1");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
